// File: rtl/axil_dp_ram.sv
// True dual-port 32-bit word RAM: AXI4-Lite slave on port A, native synchronous port B.
// Define DP_RAM_COLLISION_CNT_EN to add the b_collision_cnt same-word write-collision counter.
module axil_dp_ram #(
  parameter int DEPTH_LOG2 = 10,
  parameter int AXI_ADDR_W = 12,
  parameter int B_LATENCY  = 1
) (
  input  logic                  s_axi_aclk,
  input  logic                  s_axi_aresetn,
  input  logic [AXI_ADDR_W-1:0] s_axi_awaddr,
  input  logic [2:0]            s_axi_awprot,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [31:0]           s_axi_wdata,
  input  logic [3:0]            s_axi_wstrb,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [AXI_ADDR_W-1:0] s_axi_araddr,
  input  logic [2:0]            s_axi_arprot,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [31:0]           s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  input  logic                  bram_b_en,
  input  logic [3:0]            bram_b_we,
  input  logic [DEPTH_LOG2-1:0] bram_b_addr,
  input  logic [31:0]           bram_b_din,
  output logic [31:0]           bram_b_dout
`ifdef DP_RAM_COLLISION_CNT_EN
  ,
  output logic [15:0]           b_collision_cnt
`endif
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  localparam logic [1:0] W_IDLE = 2'd0, W_EXEC = 2'd1, W_RESP = 2'd2;
  localparam logic [1:0] R_IDLE = 2'd0, R_EXEC = 2'd1, R_RESP = 2'd2;

  logic clk, rst_n;
  assign clk   = s_axi_aclk;
  assign rst_n = s_axi_aresetn;

  logic [31:0] mem [DEPTH];

  logic [1:0]            w_state, r_state;
  logic                  ready_en;
  logic                  aw_held, w_held;
  logic [DEPTH_LOG2-1:0] aw_idx_q, ar_idx_q;
  logic                  aw_oor_q, ar_oor_q;
  logic [31:0]           w_data_q;
  logic [3:0]            w_strb_q;
  logic                  aw_oor_in, ar_oor_in;
  logic                  aw_hs, w_hs, ar_hs, a_we;
  logic [31:0]           b_rd_q;

  wire unused_ok = &{1'b0, s_axi_awprot, s_axi_arprot, s_axi_awaddr[1:0], s_axi_araddr[1:0]};

  // Any set bit above the word index makes the access out of range.
  generate
    if (AXI_ADDR_W > DEPTH_LOG2 + 2) begin : g_hi_bits
      assign aw_oor_in = |s_axi_awaddr[AXI_ADDR_W-1:DEPTH_LOG2+2];
      assign ar_oor_in = |s_axi_araddr[AXI_ADDR_W-1:DEPTH_LOG2+2];
    end else begin : g_no_hi_bits
      assign aw_oor_in = 1'b0;
      assign ar_oor_in = 1'b0;
    end
  endgenerate

  assign s_axi_awready = ready_en && (w_state == W_IDLE) && !aw_held;
  assign s_axi_wready  = ready_en && (w_state == W_IDLE) && !w_held;
  assign s_axi_arready = ready_en && (r_state == R_IDLE);
  assign aw_hs = s_axi_awvalid && s_axi_awready;
  assign w_hs  = s_axi_wvalid && s_axi_wready;
  assign ar_hs = s_axi_arvalid && s_axi_arready;
  assign a_we  = (w_state == W_EXEC) && !aw_oor_q;

  // Port B bytes are applied after port A so port B wins on overlapping strobes.
  always_ff @(posedge clk) begin
    if (a_we) begin
      for (int i = 0; i < 4; i++)
        if (w_strb_q[i]) mem[aw_idx_q][8*i +: 8] <= w_data_q[8*i +: 8];
    end
    if (bram_b_en) begin
      for (int i = 0; i < 4; i++)
        if (bram_b_we[i]) mem[bram_b_addr][8*i +: 8] <= bram_b_din[8*i +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en     <= 1'b0;
      w_state      <= W_IDLE;
      aw_held      <= 1'b0;
      w_held       <= 1'b0;
      aw_idx_q     <= '0;
      aw_oor_q     <= 1'b0;
      w_data_q     <= '0;
      w_strb_q     <= '0;
      s_axi_bvalid <= 1'b0;
      s_axi_bresp  <= 2'b00;
    end else begin
      ready_en <= 1'b1;
      case (w_state)
        W_IDLE: begin
          if (aw_hs) begin
            aw_idx_q <= s_axi_awaddr[DEPTH_LOG2+1:2];
            aw_oor_q <= aw_oor_in;
            aw_held  <= 1'b1;
          end
          if (w_hs) begin
            w_data_q <= s_axi_wdata;
            w_strb_q <= s_axi_wstrb;
            w_held   <= 1'b1;
          end
          if ((aw_held || aw_hs) && (w_held || w_hs)) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            w_state <= W_EXEC;
          end
        end
        W_EXEC: begin
          s_axi_bvalid <= 1'b1;
          s_axi_bresp  <= aw_oor_q ? 2'b10 : 2'b00;
          w_state      <= W_RESP;
        end
        W_RESP: begin
          if (s_axi_bready) begin
            s_axi_bvalid <= 1'b0;
            w_state      <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // A read yields to a coinciding write so it returns the freshly written word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= R_IDLE;
      ar_idx_q     <= '0;
      ar_oor_q     <= 1'b0;
      s_axi_rvalid <= 1'b0;
      s_axi_rdata  <= '0;
      s_axi_rresp  <= 2'b00;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ar_hs) begin
            ar_idx_q <= s_axi_araddr[DEPTH_LOG2+1:2];
            ar_oor_q <= ar_oor_in;
            r_state  <= R_EXEC;
          end
        end
        R_EXEC: begin
          if (w_state != W_EXEC) begin
            s_axi_rdata  <= ar_oor_q ? 32'h0 : mem[ar_idx_q];
            s_axi_rresp  <= ar_oor_q ? 2'b10 : 2'b00;
            s_axi_rvalid <= 1'b1;
            r_state      <= R_RESP;
          end
        end
        R_RESP: begin
          if (s_axi_rready) begin
            s_axi_rvalid <= 1'b0;
            r_state      <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) b_rd_q <= '0;
    else if (bram_b_en) b_rd_q <= mem[bram_b_addr];
  end

  generate
    if (B_LATENCY == 2) begin : g_b_lat2
      logic        b_en_q;
      logic [31:0] b_out_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          b_en_q  <= 1'b0;
          b_out_q <= '0;
        end else begin
          b_en_q <= bram_b_en;
          if (b_en_q) b_out_q <= b_rd_q;
        end
      end
      assign bram_b_dout = b_out_q;
    end else begin : g_b_lat1
      assign bram_b_dout = b_rd_q;
    end
  endgenerate

`ifdef DP_RAM_COLLISION_CNT_EN
  logic collide;
  assign collide = a_we && bram_b_en && (aw_idx_q == bram_b_addr) && |(w_strb_q & bram_b_we);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) b_collision_cnt <= '0;
    else if (collide && b_collision_cnt != 16'hFFFF) b_collision_cnt <= b_collision_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_axil_dp_ram.sv
// Directed self-checking bench for axil_dp_ram (two instances: port-B latency 1 and 2).
// Honours DP_RAM_COLLISION_CNT_EN when the design is built with the collision counter.
module tb_axil_dp_ram;
  localparam int DL = 10;
  localparam int AW = 13;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [AW-1:0] s_axi_awaddr = '0, s_axi_araddr = '0;
  logic [2:0]    s_axi_awprot = '0, s_axi_arprot = '0;
  logic          s_axi_awvalid = 0, s_axi_wvalid = 0, s_axi_bready = 0;
  logic          s_axi_arvalid = 0, s_axi_rready = 0;
  logic [31:0]   s_axi_wdata = '0;
  logic [3:0]    s_axi_wstrb = '0;
  logic          bram_b_en = 0;
  logic [3:0]    bram_b_we = '0;
  logic [DL-1:0] bram_b_addr = '0;
  logic [31:0]   bram_b_din = '0;

  logic        s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid;
  logic [1:0]  s_axi_bresp, s_axi_rresp;
  logic [31:0] s_axi_rdata, dout1, dout2;
  logic        unused_awready2, unused_wready2, unused_bvalid2, unused_arready2, unused_rvalid2;
  logic [1:0]  unused_bresp2, unused_rresp2;
  logic [31:0] unused_rdata2;
`ifdef DP_RAM_COLLISION_CNT_EN
  logic [15:0] coll_cnt, unused_coll_cnt2;
`endif

  axil_dp_ram #(.DEPTH_LOG2(DL), .AXI_ADDR_W(AW), .B_LATENCY(1)) dut1 (
    .s_axi_aclk(clk), .s_axi_aresetn(rst_n),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arprot(s_axi_arprot),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .bram_b_en(bram_b_en), .bram_b_we(bram_b_we), .bram_b_addr(bram_b_addr),
    .bram_b_din(bram_b_din), .bram_b_dout(dout1)
`ifdef DP_RAM_COLLISION_CNT_EN
    , .b_collision_cnt(coll_cnt)
`endif
  );

  axil_dp_ram #(.DEPTH_LOG2(DL), .AXI_ADDR_W(AW), .B_LATENCY(2)) dut2 (
    .s_axi_aclk(clk), .s_axi_aresetn(rst_n),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(unused_awready2),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(unused_wready2),
    .s_axi_bresp(unused_bresp2), .s_axi_bvalid(unused_bvalid2), .s_axi_bready(s_axi_bready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arprot(s_axi_arprot),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(unused_arready2),
    .s_axi_rdata(unused_rdata2), .s_axi_rresp(unused_rresp2),
    .s_axi_rvalid(unused_rvalid2), .s_axi_rready(s_axi_rready),
    .bram_b_en(bram_b_en), .bram_b_we(bram_b_we), .bram_b_addr(bram_b_addr),
    .bram_b_din(bram_b_din), .bram_b_dout(dout2)
`ifdef DP_RAM_COLLISION_CNT_EN
    , .b_collision_cnt(unused_coll_cnt2)
`endif
  );

  int errors = 0;
  int checks = 0;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic [3:0] we, input logic [DL-1:0] addr,
                               input logic [31:0] din);
    @(negedge clk);
    bram_b_en = en; bram_b_we = we; bram_b_addr = addr; bram_b_din = din;
  endtask

  // W is presented w_lead cycles before AW; returns bresp after the B handshake.
  task automatic axi_write(input logic [AW-1:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int w_lead, output logic [1:0] resp);
    logic aw_hs, w_hs;
    bit   aw_done;
    int   n;
    aw_done = 0; n = 0;
    @(negedge clk);
    s_axi_awaddr = addr; s_axi_wdata = data; s_axi_wstrb = strb;
    s_axi_wvalid = 1'b1; s_axi_awvalid = (w_lead == 0);
    while ((!aw_done || s_axi_wvalid) && n < 50) begin
      aw_hs = s_axi_awvalid && s_axi_awready;
      w_hs  = s_axi_wvalid && s_axi_wready;
      @(negedge clk);
      n++;
      if (aw_hs) begin s_axi_awvalid = 1'b0; aw_done = 1; end
      if (w_hs) s_axi_wvalid = 1'b0;
      if (!aw_done && n >= w_lead) s_axi_awvalid = 1'b1;
    end
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    s_axi_bready = 1'b1;
    n = 0;
    while (!s_axi_bvalid && n < 50) begin @(negedge clk); n++; end
    checkOutput("bvalid_seen", 32'(s_axi_bvalid), 32'd1);
    resp = s_axi_bresp;
    @(negedge clk);
    s_axi_bready = 1'b0;
    checkOutput("bvalid_single", 32'(s_axi_bvalid), 32'd0);
  endtask

  // lat counts cycles from the AR handshake edge to rvalid.
  task automatic axi_read(input logic [AW-1:0] addr, output logic [31:0] data,
                          output logic [1:0] resp, output int lat);
    int n;
    n = 0;
    @(negedge clk);
    s_axi_araddr = addr; s_axi_arvalid = 1'b1;
    while (!s_axi_arready && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    s_axi_arvalid = 1'b0;
    lat = 0;
    while (!s_axi_rvalid && lat < 50) begin @(negedge clk); lat++; end
    data = s_axi_rdata; resp = s_axi_rresp;
    s_axi_rready = 1'b1;
    @(negedge clk);
    s_axi_rready = 1'b0;
    checkOutput("rvalid_drop", 32'(s_axi_rvalid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [1:0]  resp;
    logic [31:0] data;
    int          lat;

    // Reset values
    #12;
    checkOutput("rst_awready", 32'(s_axi_awready), 32'd0);
    checkOutput("rst_wready",  32'(s_axi_wready),  32'd0);
    checkOutput("rst_arready", 32'(s_axi_arready), 32'd0);
    checkOutput("rst_bvalid",  32'(s_axi_bvalid),  32'd0);
    checkOutput("rst_rvalid",  32'(s_axi_rvalid),  32'd0);
    checkOutput("rst_rdata",   s_axi_rdata,        32'd0);
    checkOutput("rst_resp",    32'({s_axi_bresp, s_axi_rresp}), 32'd0);
    checkOutput("rst_dout1",   dout1, 32'd0);
    checkOutput("rst_dout2",   dout2, 32'd0);
`ifdef DP_RAM_COLLISION_CNT_EN
    checkOutput("rst_coll_cnt", 32'(coll_cnt), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    #1 checkOutput("awready_before_edge", 32'(s_axi_awready), 32'd0);
    @(negedge clk);
    checkOutput("awready_after_edge", 32'(s_axi_awready), 32'd1);

    // Basic write then read
    axi_write(13'h010, 32'hDEADBEEF, 4'hF, 0, resp);
    checkOutput("wr10_bresp", 32'(resp), 32'd0);
    axi_read(13'h010, data, resp, lat);
    checkOutput("rd10_data", data, 32'hDEADBEEF);
    checkOutput("rd10_rresp", 32'(resp), 32'd0);
    checkOutput("rd10_latency", 32'(lat), 32'd1);

    // W three cycles ahead of AW, partial strobe
    axi_write(13'h020, 32'hAAAAAAAA, 4'hF, 0, resp);
    axi_write(13'h020, 32'h12345678, 4'h3, 3, resp);
    checkOutput("wr20_bresp", 32'(resp), 32'd0);
    axi_read(13'h020, data, resp, lat);
    checkOutput("rd20_data", data, 32'hAAAA5678);

    // Out-of-range aliases word 0 but must not touch it
    axi_write(13'h000, 32'h0BADF00D, 4'hF, 0, resp);
    axi_write(13'h1000, 32'hFFFFFFFF, 4'hF, 0, resp);
    checkOutput("oor_bresp", 32'(resp), 32'd2);
    axi_read(13'h000, data, resp, lat);
    checkOutput("word0_intact", data, 32'h0BADF00D);
    axi_read(13'h1000, data, resp, lat);
    checkOutput("oor_rdata", data, 32'h0);
    checkOutput("oor_rresp", 32'(resp), 32'd2);

    // Port B latency, read-first and hold on both instances
    applyStimulus(1'b1, 4'hF, 10'd5, 32'h00000000);
    applyStimulus(1'b1, 4'hF, 10'd5, 32'hCAFEF00D);
    applyStimulus(1'b1, 4'h0, 10'd5, 32'h00000000);
    checkOutput("b_read_first", dout1, 32'h00000000);
    applyStimulus(1'b0, 4'h0, 10'd5, 32'h00000000);
    checkOutput("b_lat1_data", dout1, 32'hCAFEF00D);
    checkOutput("b_lat2_early", dout2, 32'h00000000);
    @(negedge clk);
    checkOutput("b_lat1_hold", dout1, 32'hCAFEF00D);
    checkOutput("b_lat2_data", dout2, 32'hCAFEF00D);
    @(negedge clk);
    checkOutput("b_lat2_hold", dout2, 32'hCAFEF00D);
    axi_read(13'h014, data, resp, lat);
    checkOutput("rd14_from_b", data, 32'hCAFEF00D);

    // Same-cycle write collision on word 7
    @(negedge clk);
    s_axi_awaddr = 13'h01C; s_axi_wdata = 32'h11111111; s_axi_wstrb = 4'hF;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
    @(negedge clk);
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    bram_b_en = 1'b1; bram_b_we = 4'h3; bram_b_addr = 10'd7; bram_b_din = 32'h22222222;
    @(negedge clk);
    bram_b_en = 1'b0; bram_b_we = 4'h0;
    checkOutput("coll_bvalid", 32'(s_axi_bvalid), 32'd1);
    s_axi_bready = 1'b1;
    @(negedge clk);
    s_axi_bready = 1'b0;
    axi_read(13'h01C, data, resp, lat);
    checkOutput("coll_word", data, 32'h11112222);
`ifdef DP_RAM_COLLISION_CNT_EN
    checkOutput("coll_cnt", 32'(coll_cnt), 32'd1);
`endif

    // Reset while a response is pending
    @(negedge clk);
    s_axi_awaddr = 13'h030; s_axi_wdata = 32'h55555555; s_axi_wstrb = 4'hF;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
    @(negedge clk);
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    @(negedge clk);
    checkOutput("pend_bvalid", 32'(s_axi_bvalid), 32'd1);
    #2 rst_n = 1'b0;
    #1 checkOutput("async_bvalid_drop", 32'(s_axi_bvalid), 32'd0);
    checkOutput("async_awready_drop", 32'(s_axi_awready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    axi_write(13'h034, 32'h600DCAFE, 4'hF, 0, resp);
    checkOutput("post_rst_bresp", 32'(resp), 32'd0);
    axi_read(13'h034, data, resp, lat);
    checkOutput("post_rst_data", data, 32'h600DCAFE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
